// File: rtl/tl_memory.sv
// tl_memory: MEM pipeline stage holding the data memory, which serves byte, half and word
// loads and stores. It also resolves branches and registers results into MEM/WB.
//   i_clk, i_rst          clock, async active-low reset
//   i_alu_result          byte address / ALU value
//   i_dato2               store data
//   i_add_execute         branch target
//   i_alu_zero            ALU zero flag
//   i_write_reg           destination register
//   i_ctrl_wb             WB control (passed through)
//   i_ctrl_mem            [8]Branch [7]BranchNE [6]MemRead [5]MemWrite [4:3]size [2]Unsigned
//   i_debug_addr          debug word index -> o_debug_data (combinational)
//   o_pc_src              branch taken (combinational)
//   o_branch_target       branch target (combinational)
//   o_rd_mem_corto        ALU result forwarded to EX
//   o_write_reg_mem       destination register to forwarding unit
//   o_read_data           registered load data
//   o_alu_result          registered ALU result
//   o_write_reg           registered destination register
//   o_ctrl_wb             registered WB control
//   o_mem_error           sticky access-error flag
module tl_memory #(
    parameter int LEN                  = 32,
    parameter int NB_ADDRESS_REGISTROS = 5,
    parameter int NB_CTRL_WB           = 2,
    parameter int NB_CTRL_MEM          = 9,
    parameter int NB_ADDR_MEM          = 5
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [LEN-1:0]                  i_alu_result,
    input  logic [LEN-1:0]                  i_dato2,
    input  logic [LEN-1:0]                  i_add_execute,
    input  logic                            i_alu_zero,
    input  logic [NB_ADDRESS_REGISTROS-1:0] i_write_reg,
    input  logic [NB_CTRL_WB-1:0]           i_ctrl_wb,
    input  logic [NB_CTRL_MEM-1:0]          i_ctrl_mem,
    input  logic [NB_ADDR_MEM-1:0]          i_debug_addr,
    output logic [LEN-1:0]                  o_debug_data,
    output logic                            o_pc_src,
    output logic [LEN-1:0]                  o_branch_target,
    output logic [LEN-1:0]                  o_rd_mem_corto,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg_mem,
    output logic [LEN-1:0]                  o_read_data,
    output logic [LEN-1:0]                  o_alu_result,
    output logic [NB_ADDRESS_REGISTROS-1:0] o_write_reg,
    output logic [NB_CTRL_WB-1:0]           o_ctrl_wb,
    output logic                            o_mem_error
);
    localparam int WORDS = 2 ** NB_ADDR_MEM;
    logic [LEN-1:0] mem [WORDS];
    logic [NB_ADDR_MEM-1:0] word;
    logic [1:0] lane, size;
    logic branch, branch_ne, rd, wr, uns, err;
    logic [LEN-1:0] cur, wr_word, load_val;
    logic [7:0] byte_val;
    logic [15:0] half_val;
    logic unused_ctrl;
    assign word      = i_alu_result[NB_ADDR_MEM+1:2];
    assign lane      = i_alu_result[1:0];
    assign branch    = i_ctrl_mem[8];
    assign branch_ne = i_ctrl_mem[7];
    assign rd        = i_ctrl_mem[6];
    assign wr        = i_ctrl_mem[5];
    assign size      = i_ctrl_mem[4:3];
    assign uns       = i_ctrl_mem[2];
    assign unused_ctrl = ^i_ctrl_mem[1:0];
    // Size/alignment faults only matter when the instruction actually touches memory.
    assign err = (rd & wr) | ((rd | wr) & ((size == 2'b10) | ((size == 2'b01) & lane[0]) |
                 ((size == 2'b11) & (lane != 2'b00))));
    assign o_debug_data    = mem[i_debug_addr];
    assign o_pc_src        = (branch & i_alu_zero) | (branch_ne & ~i_alu_zero);
    assign o_branch_target = i_add_execute;
    assign o_rd_mem_corto  = i_alu_result;
    assign o_write_reg_mem = i_write_reg;
    always_comb begin
        cur      = mem[word];
        byte_val = cur[{lane, 3'b000} +: 8];
        half_val = cur[{lane[1], 4'b0000} +: 16];
        wr_word  = cur;
        if (size == 2'b00)
            wr_word[{lane, 3'b000} +: 8] = i_dato2[7:0];
        else if (size == 2'b01)
            wr_word[{lane[1], 4'b0000} +: 16] = i_dato2[15:0];
        else
            wr_word = i_dato2;
        load_val = (size == 2'b00) ? {{(LEN-8){~uns & byte_val[7]}}, byte_val} :
                   (size == 2'b01) ? {{(LEN-16){~uns & half_val[15]}}, half_val} : cur;
    end
    // Stores land mid-cycle, while the EX/MEM inputs are stable.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < WORDS; i++)
                mem[i] <= '0;
        end else if (wr && !err) begin
            mem[word] <= wr_word;
        end
    end
    // MEM/WB register shares the negedge with EX/MEM.
    always_ff @(negedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_read_data  <= '0;
            o_alu_result <= '0;
            o_write_reg  <= '0;
            o_ctrl_wb    <= '0;
            o_mem_error  <= 1'b0;
        end else begin
            o_read_data  <= (rd && !err) ? load_val : '0;
            o_alu_result <= i_alu_result;
            o_write_reg  <= i_write_reg;
            o_ctrl_wb    <= i_ctrl_wb;
            o_mem_error  <= o_mem_error | err;
        end
    end
endmodule

// File: tb/tb_tl_memory.sv
// tb_tl_memory: randomized + directed bench for tl_memory against a byte-array reference model
module tb_tl_memory;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [31:0] i_alu_result = '0, i_dato2 = '0, i_add_execute = '0;
    logic        i_alu_zero = 1'b0;
    logic [4:0]  i_write_reg = '0;
    logic [1:0]  i_ctrl_wb = '0;
    logic [8:0]  i_ctrl_mem = '0;
    logic [4:0]  i_debug_addr = '0;
    logic [31:0] o_debug_data, o_branch_target, o_rd_mem_corto, o_read_data, o_alu_result;
    logic        o_pc_src, o_mem_error;
    logic [4:0]  o_write_reg_mem, o_write_reg;
    logic [1:0]  o_ctrl_wb;

    tl_memory dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_alu_result(i_alu_result), .i_dato2(i_dato2),
        .i_add_execute(i_add_execute), .i_alu_zero(i_alu_zero), .i_write_reg(i_write_reg),
        .i_ctrl_wb(i_ctrl_wb), .i_ctrl_mem(i_ctrl_mem), .i_debug_addr(i_debug_addr),
        .o_debug_data(o_debug_data), .o_pc_src(o_pc_src), .o_branch_target(o_branch_target),
        .o_rd_mem_corto(o_rd_mem_corto), .o_write_reg_mem(o_write_reg_mem),
        .o_read_data(o_read_data), .o_alu_result(o_alu_result), .o_write_reg(o_write_reg),
        .o_ctrl_wb(o_ctrl_wb), .o_mem_error(o_mem_error)
    );

    always #10 i_clk = ~i_clk;

    int checks = 0, errors = 0;
    logic chk_en = 1'b0;
    logic [7:0] mb [128];
    logic err_seen = 1'b0;
    logic [31:0] pend_rd = '0, pend_alu = '0, exp_rd = '0, exp_alu = '0;
    logic [4:0]  pend_wr = '0, exp_wr = '0;
    logic [1:0]  pend_wb = '0, exp_wb = '0;
    logic        pend_err = 1'b0, exp_err = 1'b0;
    logic        st_valid = 1'b0;
    logic [6:0]  st_a = '0;
    logic [1:0]  st_sz = '0;
    logic [31:0] st_d = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] cm(input logic br, input logic bne, input logic rd,
                                      input logic wr, input logic [1:0] sz, input logic u);
        return {br, bne, rd, wr, sz, u, 2'b00};
    endfunction

    function automatic logic [31:0] model_word(input int w);
        return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 128; i++) mb[i] = 8'h00;
        err_seen = 1'b0;
        st_valid = 1'b0;
        pend_rd = '0; pend_alu = '0; pend_wr = '0; pend_wb = '0; pend_err = 1'b0;
        exp_rd = '0; exp_alu = '0; exp_wr = '0; exp_wb = '0; exp_err = 1'b0;
    endtask

    // One EX/MEM transaction presented just after a negedge; the model predicts what
    // MEM/WB will hold after the next negedge and which store lands at the posedge.
    task automatic drive(input logic [31:0] alu, input logic [31:0] d2, input logic [8:0] c,
                         input logic z, input logic [4:0] dbg);
        logic [6:0] a;
        logic [1:0] sz;
        logic rd, wr, e;
        logic [31:0] ld;
        @(negedge i_clk);
        #1;
        i_alu_result = alu; i_dato2 = d2; i_ctrl_mem = c; i_alu_zero = z; i_debug_addr = dbg;
        i_add_execute = $urandom; i_write_reg = 5'($urandom); i_ctrl_wb = 2'($urandom);
        a = alu[6:0]; sz = c[4:3]; rd = c[6]; wr = c[5];
        e = (rd && wr) || ((rd || wr) && (sz == 2'd2 || (sz == 2'd1 && a % 2 != 0) ||
            (sz == 2'd3 && a % 4 != 0)));
        ld = '0;
        if (rd && !e) begin
            if (sz == 2'd0)
                ld = c[2] ? {24'h0, mb[a]} : {{24{mb[a][7]}}, mb[a]};
            else if (sz == 2'd1)
                ld = c[2] ? {16'h0, mb[a+1], mb[a]} : {{16{mb[a+1][7]}}, mb[a+1], mb[a]};
            else
                ld = {mb[a+3], mb[a+2], mb[a+1], mb[a]};
        end
        err_seen = err_seen | e;
        pend_rd = ld; pend_alu = alu; pend_wr = i_write_reg; pend_wb = i_ctrl_wb; pend_err = err_seen;
        st_valid = wr && !e; st_a = a; st_sz = sz; st_d = d2;
    endtask

    task automatic idle(input logic [4:0] dbg);
        drive(32'h0, 32'h0, 9'h0, 1'b0, dbg);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst = 1'b0;
        clear_model();
        i_alu_result = '0; i_dato2 = '0; i_add_execute = '0; i_alu_zero = 1'b0;
        i_write_reg = '0; i_ctrl_wb = '0; i_ctrl_mem = '0;
        #1;
        chk("rst_read_data", o_read_data, 32'h0);
        chk("rst_alu_result", o_alu_result, 32'h0);
        chk("rst_write_reg", 32'(o_write_reg), 32'h0);
        chk("rst_ctrl_wb", 32'(o_ctrl_wb), 32'h0);
        chk("rst_mem_error", 32'(o_mem_error), 32'h0);
        for (int k = 0; k < 5; k++) begin
            i_debug_addr = 5'(k);
            #1;
            chk("rst_mem_zero", o_debug_data, 32'h0);
        end
        i_debug_addr = '0;
        @(negedge i_clk);
        #2;
        i_rst = 1'b1;
        chk_en = 1'b1;
    endtask

    // Compare process: every cycle, registered outputs against the model's MEM/WB
    // prediction and combinational outputs against the rules applied to current inputs.
    initial begin
        forever begin
            @(negedge i_clk);
            exp_rd = pend_rd; exp_alu = pend_alu; exp_wr = pend_wr; exp_wb = pend_wb; exp_err = pend_err;
            #8;
            if (chk_en) begin
                chk("read_data", o_read_data, exp_rd);
                chk("alu_result", o_alu_result, exp_alu);
                chk("write_reg", 32'(o_write_reg), 32'(exp_wr));
                chk("ctrl_wb", 32'(o_ctrl_wb), 32'(exp_wb));
                chk("mem_error", 32'(o_mem_error), 32'(exp_err));
                chk("pc_src", 32'(o_pc_src),
                    32'((i_ctrl_mem[8] & i_alu_zero) | (i_ctrl_mem[7] & ~i_alu_zero)));
                chk("branch_target", o_branch_target, i_add_execute);
                chk("rd_mem_corto", o_rd_mem_corto, i_alu_result);
                chk("write_reg_mem", 32'(o_write_reg_mem), 32'(i_write_reg));
                chk("debug_data", o_debug_data, model_word(int'(i_debug_addr)));
            end
            @(posedge i_clk);
            if (st_valid && i_rst) begin
                mb[st_a] = st_d[7:0];
                if (st_sz != 2'd0) mb[st_a+1] = st_d[15:8];
                if (st_sz == 2'd3) begin
                    mb[st_a+2] = st_d[23:16];
                    mb[st_a+3] = st_d[31:24];
                end
            end
        end
    end

    initial begin
        logic [31:0] tmp;
        logic [1:0] sz, lane;
        logic [8:0] c;
        int kind;
        clear_model();
        do_reset();
        drive(32'h08, 32'hDEADBEEF, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd2);
        drive(32'h08, 32'h0, cm(0, 0, 1, 0, 2'd3, 0), 0, 5'd2);
        idle(5'd2); #7;
        chk("lit_lw", o_read_data, 32'hDEADBEEF);
        chk("lit_dbg_w2", o_debug_data, 32'hDEADBEEF);
        drive(32'h0C, 32'h11223344, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd3);
        drive(32'h0D, 32'h000000AA, cm(0, 0, 0, 1, 2'd0, 0), 0, 5'd3);
        drive(32'h0D, 32'h0, cm(0, 0, 1, 0, 2'd0, 0), 0, 5'd3); #7;
        chk("lit_sb_word", o_debug_data, 32'h1122AA44);
        drive(32'h0D, 32'h0, cm(0, 0, 1, 0, 2'd0, 1), 0, 5'd3); #7;
        chk("lit_lb", o_read_data, 32'hFFFFFFAA);
        drive(32'h0E, 32'h00008001, cm(0, 0, 0, 1, 2'd1, 0), 0, 5'd3); #7;
        chk("lit_lbu", o_read_data, 32'h000000AA);
        drive(32'h0E, 32'h0, cm(0, 0, 1, 0, 2'd1, 0), 0, 5'd3); #7;
        chk("lit_sh_word", o_debug_data, 32'h8001AA44);
        drive(32'h0E, 32'h0, cm(0, 0, 1, 0, 2'd1, 1), 0, 5'd3); #7;
        chk("lit_lh", o_read_data, 32'hFFFF8001);
        idle(5'd3); #7;
        chk("lit_lhu", o_read_data, 32'h00008001);
        drive(32'h1234, 32'h0, cm(1, 0, 0, 0, 2'd0, 0), 1, 5'd0); #7;
        chk("lit_beq_taken", 32'(o_pc_src), 32'd1);
        drive(32'h0, 32'h0, cm(0, 1, 0, 0, 2'd0, 0), 1, 5'd0); #7;
        chk("lit_bne_zero", 32'(o_pc_src), 32'd0);
        drive(32'h0, 32'h0, cm(1, 1, 0, 0, 2'd0, 0), 0, 5'd0); #7;
        chk("lit_both_taken", 32'(o_pc_src), 32'd1);
        drive(32'h88, 32'hCAFEF00D, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd2);
        drive(32'h08, 32'h0, cm(0, 0, 1, 0, 2'd3, 0), 0, 5'd2); #7;
        chk("lit_alias_dbg", o_debug_data, 32'hCAFEF00D);
        idle(5'd2); #7;
        chk("lit_alias_lw", o_read_data, 32'hCAFEF00D);
        drive(32'h00, 32'hFFFFFFFF, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd1);
        drive(32'h05, 32'h12345678, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd1);
        idle(5'd1); #7;
        chk("lit_err_set", 32'(o_mem_error), 32'd1);
        chk("lit_sw_suppressed", o_debug_data, 32'h0);
        drive(32'h03, 32'h0, cm(0, 0, 1, 0, 2'd1, 0), 0, 5'd0);
        idle(5'd0); #7;
        chk("lit_lh_misaligned", o_read_data, 32'h0);
        chk("lit_err_sticky", 32'(o_mem_error), 32'd1);
        drive(32'h08, 32'h0, cm(0, 0, 1, 0, 2'd3, 0), 0, 5'd4);
        drive(32'h10, 32'h00000055, cm(0, 0, 0, 1, 2'd3, 0), 0, 5'd4);
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (n % 60 == 59) do_reset();
            tmp = $urandom;
            kind = int'($urandom_range(0, 7));
            sz = (kind % 3 == 0) ? 2'd0 : (kind % 3 == 1) ? 2'd1 : 2'd3;
            lane = 2'($urandom);
            lane = (sz == 2'd0) ? lane : (sz == 2'd1) ? {lane[1], 1'b0} : 2'd0;
            if ($urandom_range(0, 15) == 0) lane = 2'($urandom);
            c = 9'($urandom);
            if (kind <= 2) c = {c[8:7], 2'b01, sz, c[2:0]};
            else if (kind <= 5) c = {c[8:7], 2'b10, sz, c[2:0]};
            else if (kind == 6) c = {c[8:7], 2'b00, c[4:0]};
            drive({tmp[31:2], lane}, $urandom, c, 1'($urandom), 5'($urandom));
        end
        idle(5'd0);
        idle(5'd0);
        #7;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
